// File: rtl/histogram_peak_reader.sv
// histogram_peak_reader: reads x/y projection histograms and reports the peak bin of each axis
module histogram_peak_reader #(
  parameter int NUM_BINS = 256,
  parameter logic [7:0] MIN_PEAK = 8'd4,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startRead,
  output logic       readHistogram,
  input  logic [7:0] xHistogramIn,
  input  logic       xValid,
  input  logic [7:0] yHistogramIn,
  input  logic       yValid,
  output logic [7:0] xPeakIndex,
  output logic [7:0] xPeakValue,
  output logic [7:0] yPeakIndex,
  output logic [7:0] yPeakValue,
  output logic       peakFound,
  output logic       resultValid,
  output logic       busy,
  output logic       timeoutError
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [7:0] LAST = 8'(NUM_BINS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} stateT;
  stateT state;

  logic [7:0] xCnt, yCnt, xMax, yMax, xIdx, yIdx;
  logic [7:0] xMaxN, yMaxN, xIdxN, yIdxN;
  logic xDone, yDone, xDoneN, yDoneN, xAcc, yAcc, xHit, yHit;
  logic [TW-1:0] idleCnt;

  assign busy = state != IDLE;

  // next running maxima including this cycle's beats; strict compare keeps the lowest index on ties
  always_comb begin
    xAcc = state == COLLECT && xValid && !xDone;
    yAcc = state == COLLECT && yValid && !yDone;
    xHit = xAcc && xHistogramIn > xMax;
    yHit = yAcc && yHistogramIn > yMax;
    xMaxN = xHit ? xHistogramIn : xMax;
    yMaxN = yHit ? yHistogramIn : yMax;
    xIdxN = xHit ? xCnt : xIdx;
    yIdxN = yHit ? yCnt : yIdx;
    xDoneN = xDone || (xAcc && xCnt == LAST);
    yDoneN = yDone || (yAcc && yCnt == LAST);
  end

  // read sequencer: collect both streams, publish peaks on completion, abort on idle timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      readHistogram <= 1'b0;
      xPeakIndex <= '0;
      xPeakValue <= '0;
      yPeakIndex <= '0;
      yPeakValue <= '0;
      peakFound <= 1'b0;
      resultValid <= 1'b0;
      timeoutError <= 1'b0;
      xCnt <= '0;
      yCnt <= '0;
      xMax <= '0;
      yMax <= '0;
      xIdx <= '0;
      yIdx <= '0;
      xDone <= 1'b0;
      yDone <= 1'b0;
      idleCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          resultValid <= 1'b0;
          if (startRead) begin
            state <= COLLECT;
            readHistogram <= 1'b1;
            timeoutError <= 1'b0;
            xCnt <= '0;
            yCnt <= '0;
            xMax <= '0;
            yMax <= '0;
            xIdx <= '0;
            yIdx <= '0;
            xDone <= 1'b0;
            yDone <= 1'b0;
            idleCnt <= '0;
          end
        end
        COLLECT: begin
          xMax <= xMaxN;
          yMax <= yMaxN;
          xIdx <= xIdxN;
          yIdx <= yIdxN;
          xDone <= xDoneN;
          yDone <= yDoneN;
          xCnt <= xCnt + 8'(xAcc);
          yCnt <= yCnt + 8'(yAcc);
          idleCnt <= (xAcc || yAcc) ? '0 : idleCnt + TW'(1);
          if (xDoneN && yDoneN) begin
            state <= DONE;
            readHistogram <= 1'b0;
            xPeakIndex <= xIdxN;
            xPeakValue <= xMaxN;
            yPeakIndex <= yIdxN;
            yPeakValue <= yMaxN;
            peakFound <= xMaxN >= MIN_PEAK && yMaxN >= MIN_PEAK;
            resultValid <= 1'b1;
          end else if (!(xAcc || yAcc) && idleCnt == TLAST) begin
            state <= DONE;
            readHistogram <= 1'b0;
            timeoutError <= 1'b1;
          end
        end
        DONE: begin
          resultValid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_histogram_peak_reader.sv
// tb_histogram_peak_reader: randomized self-checking bench against an array-scan peak model
module tb_histogram_peak_reader;
  logic clk = 1'b0;
  logic reset, startRead, xValid, yValid;
  logic [7:0] xHistogramIn, yHistogramIn;
  logic readHistogram, peakFound, resultValid, busy, timeoutError;
  logic [7:0] xPeakIndex, xPeakValue, yPeakIndex, yPeakValue;

  always #5 clk = ~clk;

  histogram_peak_reader #(.NUM_BINS(256), .MIN_PEAK(8'd4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .startRead(startRead), .readHistogram(readHistogram),
    .xHistogramIn(xHistogramIn), .xValid(xValid), .yHistogramIn(yHistogramIn), .yValid(yValid),
    .xPeakIndex(xPeakIndex), .xPeakValue(xPeakValue), .yPeakIndex(yPeakIndex), .yPeakValue(yPeakValue),
    .peakFound(peakFound), .resultValid(resultValid), .busy(busy), .timeoutError(timeoutError)
  );

  int compared = 0, mismatched = 0;
  logic [7:0] xBins [256];
  logic [7:0] yBins [256];
  logic [7:0] expXi, expXv, expYi, expYv;
  logic expPf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // peak = largest value, then the first index that holds it
  task automatic model;
    expXv = 0;
    expYv = 0;
    foreach (xBins[i]) begin
      if (xBins[i] > expXv) expXv = xBins[i];
      if (yBins[i] > expYv) expYv = yBins[i];
    end
    expXi = 0;
    expYi = 0;
    for (int i = 255; i >= 0; i--) begin
      if (xBins[i] == expXv) expXi = 8'(i);
      if (yBins[i] == expYv) expYi = 8'(i);
    end
    expPf = expXv >= 8'd4 && expYv >= 8'd4;
  endtask

  task automatic checkPeaks(input string tag);
    check({tag, "_xi"}, xPeakIndex, expXi);
    check({tag, "_xv"}, xPeakValue, expXv);
    check({tag, "_yi"}, yPeakIndex, expYi);
    check({tag, "_yv"}, yPeakValue, expYv);
    check({tag, "_pf"}, peakFound, expPf);
  endtask

  task automatic randBins(input int hi);
    foreach (xBins[i]) begin
      xBins[i] = 8'($urandom_range(hi, 0));
      yBins[i] = 8'($urandom_range(hi, 0));
    end
  endtask

  task automatic doRead(input int xg0, xg1, yg0, yg1, extra, dupAt, output int iters);
    int xi, yi, xw, yw, ex;
    model();
    startRead = 1'b1;
    step();
    startRead = 1'b0;
    check("startCollect", {busy, readHistogram, timeoutError}, 3'b110);
    xi = 0; yi = 0; xw = 0; yw = 0; ex = extra; iters = 0;
    while (!(xi == 256 && yi == 256) && iters < 4000) begin
      startRead = iters == dupAt;
      if (xi < 256 && xw == 0) begin
        xValid = 1'b1; xHistogramIn = xBins[xi]; xi++; xw = $urandom_range(xg1, xg0);
      end else if (xi == 256 && ex > 0) begin
        xValid = 1'b1; xHistogramIn = 8'hff; ex--;
      end else begin
        xValid = 1'b0; xHistogramIn = 8'($urandom); if (xw > 0) xw--;
      end
      if (yi < 256 && yw == 0) begin
        yValid = 1'b1; yHistogramIn = yBins[yi]; yi++; yw = $urandom_range(yg1, yg0);
      end else begin
        yValid = 1'b0; yHistogramIn = 8'($urandom); if (yw > 0) yw--;
      end
      step();
      iters++;
      if (!(xi == 256 && yi == 256)) check("collecting", {readHistogram, resultValid}, 2'b10);
    end
    startRead = 1'b0; xValid = 1'b0; yValid = 1'b0;
    check("doneBound", iters < 4000, 1);
    check("doneFlags", {resultValid, readHistogram, busy}, 3'b101);
    checkPeaks("done");
    step();
    check("backIdle", {busy, resultValid}, 2'b00);
  endtask

  initial begin
    int it, cnt;
    reset = 1'b1; startRead = 1'b0; xValid = 1'b0; yValid = 1'b0;
    xHistogramIn = 8'd0; yHistogramIn = 8'd0;
    step();
    step();
    check("resetOut", {readHistogram, xPeakIndex, xPeakValue, yPeakIndex, yPeakValue, peakFound, resultValid, busy, timeoutError}, 0);
    reset = 1'b0;
    step();
    // basic peaks at full rate
    foreach (xBins[i]) begin xBins[i] = 8'(i); yBins[i] = 8'd0; end
    yBins[37] = 8'd200;
    doRead(0, 0, 0, 0, 0, -1, it);
    check("basicLatency", it, 256);
    check("basicPeaks", {xPeakIndex, xPeakValue, yPeakIndex, yPeakValue, peakFound}, {8'd255, 8'd255, 8'd37, 8'd200, 1'b1});
    // tie resolves low, below-threshold y
    foreach (xBins[i]) begin xBins[i] = 8'd0; yBins[i] = 8'd3; end
    xBins[10] = 8'd9; xBins[90] = 8'd9;
    doRead(0, 3, 0, 3, 0, -1, it);
    check("tiePeaks", {xPeakIndex, xPeakValue, yPeakIndex, yPeakValue, peakFound}, {8'd10, 8'd9, 8'd0, 8'd3, 1'b0});
    // skewed streams with late ignored x beats
    randBins(254);
    doRead(0, 0, 2, 2, 5, -1, it);
    check("skewLatency", it, 766);
    // random frames with random gaps
    for (int r = 0; r < 4; r++) begin
      randBins(r == 0 ? 6 : 255);
      doRead(0, 4, 0, 4, $urandom_range(3, 0), -1, it);
    end
    // timeout: 100 x beats then silence; previous results must persist
    startRead = 1'b1;
    step();
    startRead = 1'b0;
    for (int i = 0; i < 100; i++) begin
      xValid = 1'b1; xHistogramIn = 8'hff;
      step();
    end
    xValid = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15) check("toPending", {timeoutError, readHistogram}, 2'b01);
      if (k == 16) begin
        check("toDone", {timeoutError, resultValid, readHistogram, busy}, 4'b1001);
        checkPeaks("retain");
      end
      if (k == 17) check("toIdle", {busy, timeoutError}, 2'b01);
    end
    randBins(255);
    doRead(0, 2, 0, 2, 0, -1, it);
    // reset mid-read
    startRead = 1'b1;
    step();
    startRead = 1'b0;
    for (int i = 0; i < 50; i++) begin
      xValid = 1'b1; yValid = 1'b1; xHistogramIn = 8'($urandom); yHistogramIn = 8'($urandom);
      step();
    end
    xValid = 1'b0; yValid = 1'b0; reset = 1'b1;
    step();
    check("midReset", {readHistogram, xPeakIndex, xPeakValue, yPeakIndex, yPeakValue, peakFound, resultValid, busy, timeoutError}, 0);
    reset = 1'b0;
    step();
    check("postResetIdle", busy, 0);
    // second startRead while busy is dropped
    randBins(255);
    doRead(0, 1, 0, 1, 0, 4, it);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (resultValid) cnt++;
    end
    check("dupStartRv", cnt, 0);
    check("dupStartIdle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/histogram_peak_reader.md
# histogram_peak_reader

Consumer side of the histogram read interface. After a filtered image is complete, it requests the x and y projection histograms, receives both bin streams, and reports the index and value of the maximum bin of each axis. It sits downstream of the histogram computation and supplies a per-frame object position (peak column and peak row) to the control logic.

## Interface

- NUM_BINS, 256: bins per axis; bin index is 8 bits, so the legal range is 2..256.
- MIN_PEAK, 8'd4: minimum peak value for an axis to count as a detection.
- TIMEOUT, 1024: idle cycles without a valid beat before the read is aborted; minimum 2.

Ports:

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startRead  in  1  single-cycle request to read the histograms. Normally wired to fullImageDone.
- readHistogram  out  1  held high while the histograms are being read.
- xHistogramIn  in  8  x-axis bin value. Bins arrive in index order 0..NUM_BINS-1.
- xValid  in  1  xHistogramIn carries a valid bin this cycle.
- yHistogramIn  in  8  y-axis bin value. Bins arrive in index order 0..NUM_BINS-1.
- yValid  in  1  yHistogramIn carries a valid bin this cycle.
- xPeakIndex  out  8  index of the maximum x bin.
- xPeakValue  out  8  value of the maximum x bin.
- yPeakIndex  out  8  index of the maximum y bin.
- yPeakValue  out  8  value of the maximum y bin.
- peakFound  out  1  high when xPeakValue >= MIN_PEAK and yPeakValue >= MIN_PEAK.
- resultValid  out  1  one-cycle pulse when the results are updated.
- busy  out  1  high in any state other than IDLE.
- timeoutError  out  1  sticky error flag. Cleared by the next accepted startRead or by reset.

## Operation

**FSM states: IDLE, COLLECT, DONE.**

- **IDLE.** startRead=1 moves the FSM to COLLECT. On that transition:
  - clear both bin counters, both "stream complete" flags, the running maxima and indices, and the timeout counter;
  - clear timeoutError.
- **COLLECT.**
  - readHistogram=1 throughout.
  - The x stream and the y stream are handled independently. The two streams may interleave, may arrive simultaneously, and may have gaps.
  - **x stream beat.** Each cycle with xValid=1 and the x stream not yet complete:
    - if xHistogramIn > the running x maximum (strict greater-than), load the maximum with xHistogramIn and the index with the x bin counter;
    - increment the x bin counter;
    - when the beat at index NUM_BINS-1 is accepted, set the x stream complete.
  - **y stream beat.** Identical behaviour, using yValid, yHistogramIn, and the y maximum, index, counter and complete flag.
  - Because the comparison is strict, ties resolve to the lowest index. An all-zero histogram gives index 0, value 0.
  - Beats that arrive on a stream after it is complete are ignored.
  - When both streams are complete, including both completing in the same cycle, go to DONE.
  - **Timeout.** The timeout counter increments on every cycle in which neither xValid nor yValid is accepted, and resets to 0 on any accepted beat. When it reaches TIMEOUT-1:
    - set timeoutError=1;
    - go to DONE without updating any peak output.
- **DONE.** This state lasts one cycle.
  - readHistogram=0.
  - If there was no timeout: copy the running maxima and indices to the peak outputs, compute peakFound from them, and pulse resultValid.
  - After a timeout, the peak outputs, peakFound and resultValid are not changed.
  - Next state is IDLE.
- **Outputs between reads.** The peak outputs and peakFound hold their values until the next successful DONE.
- **startRead while busy** (COLLECT or DONE) is ignored and is not queued.
- **xValid/yValid in IDLE** are ignored.
- **Reset at any time, including mid-COLLECT**, returns the FSM to IDLE.
  - All outputs are 0 during reset and immediately after it: readHistogram, all peak outputs, peakFound, resultValid, busy, timeoutError.
  - Any read that was in progress is discarded.

## Timing

- startRead high in cycle T → in T+1, state is COLLECT and readHistogram=busy=1.
- A beat is accepted on the rising edge at the end of the cycle in which its valid is high. The first beat may arrive in T+1.
- Last required beat accepted in cycle E → in E+1, state is DONE, resultValid=1, readHistogram=0, and the peak outputs show their new values. In E+2, state is IDLE and busy=0.
- **Minimum read latency**, with both streams at full rate in parallel: NUM_BINS+1 cycles from startRead to resultValid.
- **Timeout timing:** after the last accepted beat, TIMEOUT cycles with no beat lead to DONE, with timeoutError high from that DONE cycle onward.
- A new startRead is accepted no earlier than E+2.

## Test plan

- **Basic peaks.** Reset; then startRead; x stream has x[i]=i for i=0..255; y stream has y[37]=200, all other y bins 0. → xPeakIndex=255, xPeakValue=255, yPeakIndex=37, yPeakValue=200, peakFound=1, resultValid pulses at exactly T+257.
- **Tie and threshold.** x[10]=x[90]=9 with all other x bins 0; every y bin = 3. → xPeakIndex=10, yPeakIndex=0, yPeakValue=3, peakFound=0.
- **Skewed and gapped streams.** x sent in 256 consecutive cycles; y sent one beat every 3 cycles; 5 extra x beats with value 255 sent after x completes. → the extra beats are ignored; readHistogram stays high until the y stream completes; DONE occurs in the cycle after the last y beat.
- **Timeout.** Parameters TIMEOUT=16, NUM_BINS=256. Send 100 x beats, then nothing. → after 16 idle cycles, timeoutError=1, resultValid stays low, and the outputs retain the previous frame's results. A following startRead clears timeoutError.
- **Reset mid-read and busy start.** Assert reset after 50 beats. → all outputs are 0 in the next cycle and the state is IDLE. Then pulse startRead twice, 5 cycles apart. → only the first is accepted, and exactly one resultValid is produced.
